// File: rtl/decrementa_n.sv
// Registered multi-mode decrement unit: LOAD, DEC, NEG and a self-timed COUNT
// sequenced by a small IDLE/RUN/DONE FSM behind a start/ready handshake.
module decrementa_n #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flag,
  input  logic [1:0]       select,
  input  logic             start,
  output logic             ready,
  output logic [WIDTH-1:0] O,
  output logic             Co,
  output logic             zero,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [1:0] {OP_LOAD, OP_DEC, OP_NEG, OP_COUNT} op_e;

  typedef struct packed {
    op_e              op;
    logic [WIDTH-1:0] operand;
  } req_t;

  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             co_q, co_d;
  req_t             req;

  always_comb begin
    req.op      = op_e'(select);
    req.operand = flag ? B : A;
  end

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    co_d    = co_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DONE;
          case (req.op)
            OP_LOAD: begin
              o_d  = req.operand;
              co_d = 1'b0;
            end
            OP_DEC: begin
              o_d  = o_q - STEP_W;
              co_d = (o_q < STEP_W);
            end
            OP_NEG: begin
              o_d  = ~req.operand + 1'b1;
              co_d = (req.operand == MOST_NEG);
            end
            OP_COUNT: begin
              o_d  = req.operand;
              co_d = 1'b0;
              if (req.operand != '0) state_d = S_RUN;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // Final step clamps at zero; a remainder means V was not a multiple of STEP.
        if (o_q > STEP_W) begin
          o_d = o_q - STEP_W;
        end else begin
          o_d     = '0;
          co_d    = (o_q != STEP_W);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      o_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      co_q    <= co_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign done  = (state_q == S_DONE);
  assign O     = o_q;
  assign Co    = co_q;
  assign zero  = (o_q == '0);

endmodule

// File: doc/decrementa_n.md
# decrementa_n

Parametrised, registered multi-mode decrement unit with WIDTH-bit operands, a flag-selected operand mux, a two's-complement negate mode, and a self-timed count-down mode. It replaces the 1-bit combinational decrement cell chain in the arithmetic datapath. A valid/ready start handshake and a one-cycle `done` pulse let the control FSM sequence operations without knowing their latency.

## Interface
- `WIDTH`, default 8: operand/result width; must be ≥ 2.
- `STEP`, default 1: decrement amount for DEC and COUNT; legal range 1 ≤ STEP ≤ 2^WIDTH−1.

- `clk`  in  1: single clock; every register updates on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `A`  in  WIDTH: operand 0.
- `B`  in  WIDTH: operand 1.
- `flag`  in  1: operand select; 0 selects A, 1 selects B. Sampled only at accept.
- `select`  in  2: op code. 0 = LOAD, 1 = DEC, 2 = NEG, 3 = COUNT. Sampled only at accept.
- `start`  in  1: request valid.
- `ready`  out  1: high only in IDLE.
- `O`  out  WIDTH: result register.
- `Co`  out  1: registered borrow/overflow flag for the last operation.
- `zero`  out  1: combinational `O == 0`.
- `done`  out  1: one-cycle pulse when an operation completes.

## Operation
- FSM states: IDLE, RUN, DONE. Reset forces IDLE, O=0, Co=0, done=0. After reset, ready=1 and zero=1.
- Accept: the rising edge where `start & ready` = 1. The operand is `flag ? B : A` and is captured at that edge. `start` is ignored while ready=0; there is no queuing.
- LOAD: O ← operand; Co ← 0. Next state DONE.
- DEC: O ← (O − STEP) mod 2^WIDTH; Co ← (O < STEP). The operand is not used. Next state DONE.
- NEG: O ← (~operand + 1) mod 2^WIDTH; Co ← 1 only when operand = 100…0 (the most negative value, whose negation overflows).
  - NEG of 0 gives O=0, Co=0.
  - Next state DONE.
- COUNT: O ← operand; Co ← 0.
  - If operand = 0, next state is DONE; otherwise next state is RUN.
  - Each RUN edge with O > STEP: O ← O − STEP; stay in RUN.
  - RUN edge with O ≤ STEP: O ← 0; Co ← (O ≠ STEP), meaning the operand was not a multiple of STEP. Next state DONE.
  - COUNT never wraps below 0.
- DONE: done=1 for exactly this cycle. Next state is IDLE unconditionally. O and Co hold.
- In IDLE, O and Co hold indefinitely.
- Reset mid-operation (any state): the next edge with rst_n=0 gives IDLE, O=0, Co=0, done=0. No done pulse is issued for the aborted operation.

## Timing
- `ready` = (state == IDLE), combinational from the state register. `done` = (state == DONE).
- LOAD, DEC and NEG: O and Co are valid the cycle after the accept edge; done is high in that same cycle. ready returns one cycle later. Throughput is 1 op per 2 cycles.
- COUNT with operand V > 0: the accept edge loads V. Then ceil(V/STEP) RUN edges follow, the last one writing O=0. done is high in the cycle after that last edge.
  - Total accept-to-done latency: ceil(V/STEP)+1 cycles.
  - COUNT with V = 0: done is high 1 cycle after accept.
- `start` held high continuously: a new op is accepted on the first edge where ready=1, i.e. the edge that leaves DONE is not an accept edge.
- `zero` tracks O combinationally and is valid in every cycle, including mid-RUN.

## Test plan
- Reset: drive rst_n=0 for 2 edges with random inputs → O=0, Co=0, zero=1, ready=1, done=0. Assert rst_n=0 mid-RUN of COUNT V=200 → IDLE, O=0, and no done pulse.
- LOAD/flag (WIDTH=8): A=0x3C, B=0xA5, flag=1, select=0 → O=0xA5, Co=0, done high 1 cycle after accept, ready high one cycle later. Repeat with flag=0 → O=0x3C.
- DEC wrap (STEP=1): LOAD 0x01, then DEC → O=0x00, Co=0, zero=1. DEC again → O=0xFF, Co=1, zero=0.
- NEG: operand 0x05 → O=0xFB, Co=0. Operand 0x80 → O=0x80, Co=1. Operand 0x00 → O=0x00, Co=0.
- COUNT (STEP=1): V=5 → O sequence 5,4,3,2,1,0 on consecutive cycles; done 6 cycles after accept; Co=0. With STEP=3: V=7 → 7,4,1,0; Co=1; done 4 cycles after accept. V=0 → done 1 cycle after accept.
- Handshake: pulse start during RUN and during DONE → ignored, O is unaffected. Hold start high with select=1 → DEC accepted every 2 cycles.
